fft_reorder64: RTL
==================

Name: fft_reorder64

Overview:
- Output reorder buffer at the tail of the 64-point SDF FFT pipeline.
- Accepts the non-stallable, bit-reversed-order sample stream from the last butterfly stage and re-emits each 64-sample frame in natural order.
- Downstream side uses a valid/ready handshake.
- Ping-pong storage (2 banks x 64 complex words) lets a frame drain while the next one fills.

Parameters:
- WIDTH, 19, bit width of each real/imag sample (pipeline output width).
- LOG2N, 6, log2 of frame length; fixed at 6 for this design (64 points).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample valid; no backpressure, accepted every asserted cycle
- in_sop  in  1  first sample of a frame; qualified by in_valid
- in_re  in  WIDTH  input real, bit-reversed frame order
- in_im  in  WIDTH  input imag
- out_ready  in  1  downstream accepts the current output
- out_valid  out  1  output sample valid
- out_sop  out  1  natural index 0 of the frame
- out_eop  out  1  natural index 63 of the frame
- out_re  out  WIDTH  output real, natural order
- out_im  out  WIDTH  output imag
- ovf_clr  in  1  clears the sticky error flags
- ovf  out  1  sticky: an incoming frame was dropped because no bank was free
- sync_err  out  1  sticky: in_sop arrived mid-frame

Behaviour:
- Reset values: out_valid=0, out_sop=0, out_eop=0, out_re=0, out_im=0, ovf=0, sync_err=0.
- Reset internal state: wcnt=0, rcnt=0, wbank=0, rbank=0, both bank_full=0, drop=0. Storage contents are don't-care.
- Write side, each cycle with in_valid=1:
  - Store {in_re,in_im} to bank wbank at address bitrev6(wcnt), unless drop=1. Then wcnt++ (6-bit wrap).
  - in_sop=1 forces the sample to be index 0 (wcnt treated as 0, next wcnt=1).
  - If in_sop=1 while wcnt!=0: set sync_err and discard the partial frame (bank stays not full).
- Frame start: when index 0 is accepted and bank_full[wbank]=1, set drop=1 for the whole frame and set ovf. A dropped frame writes nothing and does not toggle wbank.
- Frame end: on index 63 with drop=0, set bank_full[wbank]=1 and toggle wbank. On index 63 with drop=1, clear drop.
- Read side:
  - Storage is read asynchronously; the output register loads when (!out_valid || out_ready) and bank_full[rbank]=1.
  - Load values: out_re/out_im = bank[rbank][rcnt], out_sop = (rcnt==0), out_eop = (rcnt==63), out_valid=1. Then rcnt++.
  - When the loaded word has rcnt==63: clear bank_full[rbank], toggle rbank, rcnt wraps to 0.
  - If the load condition holds but the bank is empty and out_ready=1, out_valid drops to 0.
- Handshake:
  - out_* are held stable while out_valid=1 and out_ready=0.
  - A transfer occurs when out_valid && out_ready.
  - A new word may load in the same cycle as a transfer, so full throughput is 1 word/cycle.
- Latency: the last input sample (index 63) accepted in cycle t gives out_valid=1 with out_sop in cycle t+1, provided the output register is free.
- Simultaneous events:
  - A write completing bank A and a read emptying bank B in the same cycle are both honoured.
  - A read of bank B while bank A is being written never conflicts: the banks are distinct.
  - A write frame may start into a bank in the same cycle its last word is loaded out. bank_full clears first, so no drop occurs.
- Flags: ovf_clr=1 clears ovf and sync_err. If a set event occurs in the same cycle, set wins.
- Reset mid-operation discards all frames. Outputs return to reset values asynchronously.

Decomposition:
- Shared FFT package holds:
  - constant FFT_N=64 and FFT_LOG2N=6;
  - the bit-reverse function bitrev6;
  - the complex sample pair type {re,im} of WIDTH bits.
- One sub-module: fft_pingpong_ram. Two banks x 64 x 2*WIDTH, one synchronous write port (bank, addr, data, we), one asynchronous read port (bank, addr).
- Counters, bank_full flags, drop logic and the output register stay in fft_reorder64.

Test Plan:
- Single frame, out_ready=1 throughout: input sample k (sop at k=0) carries re=bitrev6(k), im=-bitrev6(k). Expect out_valid from the cycle after the last input, then outputs re=0..63 and im=0..-63 in natural order, out_sop on re=0, out_eop on re=63.
- Continuous back-to-back: 4 frames with no gaps, out_ready=1. Expect 256 contiguous outputs, each frame in natural order, ovf=0.
- Backpressure: out_ready toggles 1,0,0,1 repeating over 2 frames. Expect no lost or duplicated words and outputs stable while stalled. A 3rd frame starting while both banks are full sets ovf=1, and that frame is absent from the output.
- Resync: in_sop asserted again at wcnt=20. Expect sync_err=1, no output from the partial frame, the following complete frame emitted correctly. ovf_clr=1 returns sync_err to 0.
- Reset mid-drain: assert rst_n=0 after 10 outputs of a frame. Expect out_valid=0 immediately. A fresh frame after release emits indices 0..63 correctly.
- Gapped input: in_valid=1 every 3rd cycle for one frame. Expect correct natural-order output starting 1 cycle after sample 63 is accepted.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, sample type and index helpers for the 64-point FFT pipeline.
package fft_pkg;

    localparam int unsigned FFT_N     = 64;
    localparam int unsigned FFT_LOG2N = 6;
    localparam int unsigned FFT_WIDTH = 19;

    typedef struct packed {
        logic signed [FFT_WIDTH-1:0] re;
        logic signed [FFT_WIDTH-1:0] im;
    } cplx_t;

    function automatic logic [5:0] bitrev6(input logic [5:0] a);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) begin
            r[i] = a[5-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store: one synchronous write port, one asynchronous read port.
module fft_pingpong_ram #(
    parameter int unsigned DW = 38,
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wbank,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rbank,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2 << AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wbank, waddr}] <= wdata;
        end
    end

    assign rdata = mem[{rbank, raddr}];

endmodule

// File: rtl/fft_reorder64.sv
// Reorders bit-reversed 64-sample FFT frames into natural order through ping-pong banks,
// with a valid/ready output register and sticky overflow / resync flags.
module fft_reorder64
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned LOG2N = FFT_LOG2N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    input  logic             ovf_clr,
    output logic             ovf,
    output logic             sync_err
);

    logic [LOG2N-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, idx;
    logic             wbank_q, wbank_d, rbank_q, rbank_d;
    logic             drop_q, drop_d;
    logic [1:0]       full_q, full_d;
    logic             ovf_q, ovf_d, sync_q, sync_d;
    logic             valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic [WIDTH-1:0] re_q, re_d, im_q, im_d;

    logic             first, last, out_free, rd_done, wfull_eff, drop_eff;
    logic             we, wr_done, rd_avail, load;
    logic [2*WIDTH-1:0] rdata;

    always_comb begin
        idx      = in_sop ? '0 : wcnt_q;
        first    = in_valid && (idx == '0);
        last     = in_valid && (idx == '1);
        out_free = !valid_q || out_ready;
        rd_done  = out_free && full_q[rbank_q] && (rcnt_q == '1);
        // A bank whose last word leaves this cycle is already free for a new frame.
        wfull_eff = full_q[wbank_q] && !(rd_done && (rbank_q == wbank_q));
        drop_eff  = first ? wfull_eff : drop_q;
        we        = in_valid && !drop_eff;
        wr_done   = last && !drop_eff;
        // Bypass lets word 0 load in the same cycle the frame completes.
        rd_avail  = full_q[rbank_q] || (wr_done && (wbank_q == rbank_q));
        load      = out_free && rd_avail;
    end

    fft_pingpong_ram #(
        .DW (2 * WIDTH),
        .AW (LOG2N)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .wbank (wbank_q),
        .waddr (bitrev6(idx)),
        .wdata ({in_re, in_im}),
        .rbank (rbank_q),
        .raddr (rcnt_q),
        .rdata (rdata)
    );

    always_comb begin
        wcnt_d  = wcnt_q;
        drop_d  = drop_q;
        full_d  = full_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        rcnt_d  = rcnt_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        re_d    = re_q;
        im_d    = im_q;

        if (in_valid) begin
            wcnt_d = idx + 1'b1;
        end
        if (first) begin
            drop_d = wfull_eff;
        end else if (last && drop_eff) begin
            drop_d = 1'b0;
        end

        if (load) begin
            re_d    = rdata[2*WIDTH-1:WIDTH];
            im_d    = rdata[WIDTH-1:0];
            sop_d   = (rcnt_q == '0);
            eop_d   = (rcnt_q == '1);
            valid_d = 1'b1;
            rcnt_d  = rcnt_q + 1'b1;
            if (rcnt_q == '1) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = !rbank_q;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        if (wr_done) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = !wbank_q;
        end

        ovf_d  = (first && wfull_eff) || (ovf_q && !ovf_clr);
        sync_d = (in_valid && in_sop && (wcnt_q != '0)) || (sync_q && !ovf_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            drop_q  <= 1'b0;
            full_q  <= '0;
            ovf_q   <= 1'b0;
            sync_q  <= 1'b0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            drop_q  <= drop_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            sync_q  <= sync_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign out_re    = re_q;
    assign out_im    = im_q;
    assign ovf       = ovf_q;
    assign sync_err  = sync_q;

endmodule
